// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [1:0] {
      MDU_MULT  = 2'b00,
      MDU_MULTU = 2'b01,
      MDU_DIV   = 2'b10,
      MDU_DIVU  = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10
   } mdu_state_e;

   localparam int unsigned MDU_ITER = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO registers.
// Magnitudes are processed unsigned; signs are re-applied in the FIX state.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned CNT_W = $clog2(MDU_ITER);

   mdu_state_e         state, state_next;
   logic [CNT_W-1:0]   cnt;
   logic               is_div;
   logic               dz;
   logic               neg_lo;
   logic               neg_hi;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] acc;

   logic               signed_op_c, sign_a_c, sign_b_c, div_zero_c;
   logic [WIDTH-1:0]   mag_a_c, mag_b_c;
   logic [WIDTH:0]     add_a_c, add_b_c;
   logic [WIDTH+1:0]   sum_c;
   logic [2*WIDTH-1:0] acc_next_c;
   logic [2*WIDTH-1:0] prod_fix_c;
   logic [WIDTH-1:0]   quot_fix_c, rem_fix_c;

   // Operand magnitudes; only signed ops take the absolute value
   always_comb begin
      signed_op_c = ~op[0];
      sign_a_c    = signed_op_c & A[WIDTH-1];
      sign_b_c    = signed_op_c & B[WIDTH-1];
      mag_a_c     = sign_a_c ? -A : A;
      mag_b_c     = sign_b_c ? -B : B;
      div_zero_c  = op[1] && (B == '0);
   end

   // One shared adder: add for multiply, trial subtract (carry = no borrow) for divide
   always_comb begin
      add_a_c = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
      add_b_c = is_div ? ~{1'b0, opnd} : {1'b0, opnd};
      sum_c   = {1'b0, add_a_c} + {1'b0, add_b_c} + (WIDTH+2)'(is_div);
      if (!is_div) begin
         acc_next_c = acc[0] ? {sum_c[WIDTH:0], acc[WIDTH-1:1]}
                             : {1'b0, acc[2*WIDTH-1:1]};
      end else if (sum_c[WIDTH+1]) begin
         acc_next_c = {sum_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next_c = {acc[2*WIDTH-2:0], 1'b0};
      end
   end

   always_comb begin
      prod_fix_c = neg_lo ? -acc : acc;
      quot_fix_c = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix_c  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = div_zero_c ? FIX : CALC;
         CALC:    if (cnt == CNT_W'(MDU_ITER - 1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         is_div      <= 1'b0;
         dz          <= 1'b0;
         neg_lo      <= 1'b0;
         neg_hi      <= 1'b0;
         opnd        <= '0;
         acc         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         HI          <= '0;
         LO          <= '0;
      end else begin
         state <= state_next;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  cnt         <= '0;
                  is_div      <= op[1];
                  dz          <= div_zero_c;
                  if (op[1]) begin
                     // Divide by zero preloads the final HI/LO with no sign fix
                     opnd   <= mag_b_c;
                     acc    <= div_zero_c ? {A, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, mag_a_c};
                     neg_lo <= !div_zero_c && (sign_a_c ^ sign_b_c);
                     neg_hi <= !div_zero_c && sign_a_c;
                  end else begin
                     opnd   <= mag_a_c;
                     acc    <= {{WIDTH{1'b0}}, mag_b_c};
                     neg_lo <= sign_a_c ^ sign_b_c;
                     neg_hi <= 1'b0;
                  end
               end else begin
                  if (hi_we) HI <= wdata;
                  if (lo_we) LO <= wdata;
               end
            end
            CALC: begin
               acc <= acc_next_c;
               cnt <= cnt + CNT_W'(1);
            end
            FIX: begin
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= dz;
               if (is_div) begin
                  HI <= rem_fix_c;
                  LO <= quot_fix_c;
               end else begin
                  HI <= prod_fix_c[2*WIDTH-1:WIDTH];
                  LO <= prod_fix_c[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule
